// File: rtl/adder_16bit.sv
// Registered WIDTH-bit adder with carry, signed-overflow and zero flags, one-cycle latency.
// Optional feature: define ADDER_SATURATE_EN to clamp R to the signed limit on overflow.
module adder_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] r_q,     r_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;
    logic             zero_q,  zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] res;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign sum_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

`ifdef ADDER_SATURATE_EN
    // Overflow direction follows the operand sign: positive overflow clamps high, negative low.
    always_comb begin
        res = sum[WIDTH-1:0];
        if (sum_ovf) begin
            res = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res = sum[WIDTH-1:0];
`endif

    always_comb begin
        r_d     = r_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (in_valid) begin
            r_d     = res;
            carry_d = sum[WIDTH];
            ovf_d   = sum_ovf;
            zero_d  = (res == '0);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign R         = r_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_16bit.sv
// Randomized self-checking bench for adder_16bit against an integer-arithmetic reference model.
// Honours ADDER_SATURATE_EN when the design is built with it.
module tb_adder_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A, B;
    logic [15:0] R;
    logic        carry, ovf, zero, out_valid;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] exp_r;
    logic        exp_c, exp_o, exp_z, exp_v;

    adder_16bit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .R         (R),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    task automatic model(input logic rst, input logic v, input logic [15:0] a, input logic [15:0] b);
        int unsigned us;
        int          sa, sb, ss;
        if (!rst) begin
            exp_r = 16'h0000; exp_c = 1'b0; exp_o = 1'b0; exp_z = 1'b1; exp_v = 1'b0;
        end else if (v) begin
            us    = int'(a) + int'(b);
            sa    = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
            sb    = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
            ss    = sa + sb;
            exp_c = (us >= 65536);
            exp_o = (ss > 32767) || (ss < -32768);
            exp_r = 16'(us % 65536);
`ifdef ADDER_SATURATE_EN
            if (exp_o) exp_r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
            exp_z = (exp_r == 16'h0000);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [15:0] a, input logic [15:0] b);
        rst_n = rst; in_valid = v; A = a; B = b;
        @(posedge clk);
        #1;
        model(rst, v, a, b);
        check("R",         32'(R),         32'(exp_r));
        check("carry",     32'(carry),     32'(exp_c));
        check("ovf",       32'(ovf),       32'(exp_o));
        check("zero",      32'(zero),      32'(exp_z));
        check("out_valid", 32'(out_valid), 32'(exp_v));
    endtask

    initial begin
        logic [15:0] a, b;
        logic        v;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;

        // Reset held for two cycles
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("reset_R", 32'(R), 32'h0);
        check("reset_zero", 32'(zero), 32'h1);

        // Back-to-back pairs
        step(1'b1, 1'b1, 16'd5,   16'd5);
        check("b2b_R0", 32'(R), 32'd10);
        step(1'b1, 1'b1, 16'd100, 16'd200);
        check("b2b_R1", 32'(R), 32'd300);
        step(1'b1, 1'b1, 16'd1,   16'd1);
        check("b2b_R2", 32'(R), 32'd2);
        step(1'b1, 1'b1, 16'd10,  16'd17);
        check("b2b_R3", 32'(R), 32'd27);
        step(1'b1, 1'b1, 16'd69,  16'd69);
        check("b2b_R4", 32'(R), 32'd138);

        // Boundaries
        step(1'b1, 1'b1, 16'hFFFF, 16'h0001);
        check("wrap_R", 32'(R), 32'h0000);
        check("wrap_carry", 32'(carry), 32'h1);
        step(1'b1, 1'b1, 16'h7FFF, 16'h0001);
`ifdef ADDER_SATURATE_EN
        check("pos_ovf_R", 32'(R), 32'h7FFF);
`else
        check("pos_ovf_R", 32'(R), 32'h8000);
`endif
        check("pos_ovf_flag", 32'(ovf), 32'h1);
        step(1'b1, 1'b1, 16'h8000, 16'h8000);
        check("neg_ovf_carry", 32'(carry), 32'h1);

        // Hold when in_valid drops
        step(1'b1, 1'b1, 16'd1, 16'd1);
        step(1'b1, 1'b0, 16'h1234, 16'h4321);
        check("hold_R", 32'(R), 32'h0002);
        check("hold_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 'x, 'x);
        check("hold_x_R", 32'(R), 32'h0002);

        // Reset beats in_valid
        step(1'b1, 1'b1, 16'h0300, 16'h0400);
        step(1'b0, 1'b1, 16'h0100, 16'h0100);
        check("rst_win_R", 32'(R), 32'h0000);

        // Random pairs, occasionally idle or reset
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            v = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a[15:14] = b[15:14];
            end
            step(($urandom_range(0, 199) != 0), v, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
